clock_divider: RTL and testbench

CLOCK_DIVIDER -- requirements
Module: clock_divider

---
 rtl/uart_pkg.sv | 12 +
 rtl/clock_divider.sv | 47 ++++
 tb/tb_clock_divider.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default input clock and baud rate, plus counter sizing helper.
package uart_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEFAULT = 100_000_000;
    localparam int unsigned BAUD_RATE_DEFAULT   = 9600;

    // A counter spanning 0..half-1 still needs one bit when half is 1.
    function automatic int unsigned cnt_width(input int unsigned half);
        return (half <= 1) ? 1 : $clog2(half);
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Divides clk down to a 50% duty div_clk of period 2*HALF cycles, with a one-cycle
// div_tick marking each div_clk rising edge.
module clock_divider
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
    parameter int unsigned BAUD_RATE   = BAUD_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst_l,
    output logic div_clk,
    output logic div_tick
);

    // Guard the division so a zero baud rate reaches the elaboration check below.
    localparam int unsigned DIV   = (BAUD_RATE == 0) ? 0 : CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = cnt_width(HALF);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    generate
        if (BAUD_RATE == 0 || DIV < 2) begin : g_bad_params
            $error("clock_divider: BAUD_RATE must be nonzero and CLK_FREQ_HZ/BAUD_RATE >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == LAST);

    // rst_l is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            cnt      <= '0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            cnt      <= wrap ? '0 : cnt + CNT_W'(1);
            div_tick <= wrap & ~div_clk;
            if (wrap) begin
                div_clk <= ~div_clk;
            end
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider across four parameterisations.
module tb_clock_divider;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic a_clk, a_tick;
    logic b_clk, b_tick;
    logic c_clk, c_tick;
    logic d_clk, d_tick;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    // HALF = 4
    clock_divider #(.CLK_FREQ_HZ(16), .BAUD_RATE(2)) dut_a (
        .clk(clk), .rst_l(rst_a), .div_clk(a_clk), .div_tick(a_tick));
    // DIV = 2, HALF = 1
    clock_divider #(.CLK_FREQ_HZ(10), .BAUD_RATE(5)) dut_b (
        .clk(clk), .rst_l(rst_b), .div_clk(b_clk), .div_tick(b_tick));
    // DIV = 9 (odd), HALF = 4
    clock_divider #(.CLK_FREQ_HZ(18), .BAUD_RATE(2)) dut_c (
        .clk(clk), .rst_l(rst_b), .div_clk(c_clk), .div_tick(c_tick));
    // Defaults: HALF = 5208
    clock_divider dut_d (
        .clk(clk), .rst_l(rst_b), .div_clk(d_clk), .div_tick(d_tick));

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned pulses;
        int unsigned bad_clk;
        int unsigned bad_tick;
        int          last;
        int unsigned periods;
        logic        prev;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        check("a_reset_clk", a_clk, 0);
        check("a_reset_tick", a_tick, 0);
        check("a_reset_cnt", dut_a.cnt, 0);

        // Ten periods of the HALF=4 divider: low on edges 0..3, high on 4..7.
        rst_a    = 1'b0;
        pulses   = 0;
        bad_clk  = 0;
        bad_tick = 0;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (a_clk != ((n / 4) % 2)) begin
                bad_clk++;
                if (bad_clk == 1) check("a_clk_wave", a_clk, (n / 4) % 2);
            end
            if (a_tick != ((n % 8) == 4)) begin
                bad_tick++;
                if (bad_tick == 1) check("a_tick_wave", a_tick, (n % 8) == 4);
            end
            if (a_tick) pulses++;
        end
        check("a_clk_errors", bad_clk, 0);
        check("a_tick_errors", bad_tick, 0);
        check("a_tick_pulses", pulses, 10);

        // Advance to edge 86: third cycle of a high phase, cnt == 2.
        repeat (6) tick();
        check("a_mid_clk", a_clk, 1);
        check("a_mid_cnt", dut_a.cnt, 2);
        rst_a = 1'b1;
        tick();
        check("a_midrst_clk", a_clk, 0);
        check("a_midrst_cnt", dut_a.cnt, 0);
        check("a_midrst_tick", a_tick, 0);
        rst_a = 1'b0;
        repeat (3) tick();
        check("a_rel_low", a_clk, 0);
        tick();
        check("a_rel_rise", a_clk, 1);
        check("a_rel_tick", a_tick, 1);
        tick();
        check("a_rel_tick_drop", a_tick, 0);

        // HALF=1 toggles every edge; odd DIV=9 behaves as HALF=4.
        check("b_reset_clk", b_clk, 0);
        check("c_reset_clk", c_clk, 0);
        rst_b    = 1'b0;
        bad_clk  = 0;
        bad_tick = 0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            if (b_clk != (n % 2)) begin
                bad_clk++;
                if (bad_clk == 1) check("b_clk_wave", b_clk, n % 2);
            end
            if (b_tick != (n % 2)) begin
                bad_tick++;
                if (bad_tick == 1) check("b_tick_wave", b_tick, n % 2);
            end
            if (c_clk != ((n / 4) % 2)) begin
                bad_clk++;
                if (bad_clk == 1) check("c_clk_wave", c_clk, (n / 4) % 2);
            end
            if (c_tick != ((n % 8) == 4)) begin
                bad_tick++;
                if (bad_tick == 1) check("c_tick_wave", c_tick, (n % 8) == 4);
            end
        end
        check("bc_clk_errors", bad_clk, 0);
        check("bc_tick_errors", bad_tick, 0);

        // Defaults: measure three full periods between rising edges.
        last    = -1;
        periods = 0;
        prev    = d_clk;
        for (int c = 0; c < 40000 && periods < 3; c++) begin
            tick();
            if (d_clk && !prev) begin
                check("d_tick_at_rise", d_tick, 1);
                if (last >= 0) begin
                    check("d_period", c - last, 10416);
                    periods++;
                end
                last = c;
            end
            prev = d_clk;
        end
        check("d_periods_seen", periods, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
